// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes and datapath selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StAluWb, StBranch, StJal, StJalr1, StJalr2, StLui
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;
  localparam logic [1:0] ResImmExt    = 2'b11;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmU = 3'b011;
  localparam logic [2:0] ImmJ = 3'b100;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // Branch condition from the subtract flags; unlisted funct3 values never branch.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic neg);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return neg;
      3'b101:  return !neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from ALUOp and the instruction funct fields.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  op5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_CTRL_W'(AluAdd);
    case (alu_op)
      AluOpSub: alu_control = ALU_CTRL_W'(AluSub);
      AluOpFunct: begin
        case (funct3)
          // Only register-register forms may subtract; addi ignores bit 30.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_CTRL_W'(AluSub) : ALU_CTRL_W'(AluAdd);
          3'b010:  alu_control = ALU_CTRL_W'(AluSlt);
          3'b100:  alu_control = ALU_CTRL_W'(AluXor);
          3'b110:  alu_control = ALU_CTRL_W'(AluOr);
          3'b111:  alu_control = ALU_CTRL_W'(AluAnd);
          default: alu_control = ALU_CTRL_W'(AluAdd);
        endcase
      end
      default: alu_control = ALU_CTRL_W'(AluAdd);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I datapath.
// Optional MEM_READY_EN: FETCH/MEMREAD/MEMWRITE stall until mem_ready.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 7,
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  neg,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal
);

  state_e     state_q, state_d;
  logic       pc_update, branch, mem_ok;
  logic [1:0] alu_op;

`ifdef MEM_READY_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBReg;
    ImmSrc    = ImmI;
    alu_op    = AluOpAdd;
    illegal   = 1'b0;

    unique case (state_q)
      StFetch: begin
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        IRWrite   = mem_ok;
        pc_update = mem_ok;
        if (mem_ok) state_d = StDecode;
      end
      StDecode: begin
        // ALUOut <= OldPC + imm; jal needs its J immediate for the jump target.
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        ImmSrc  = (op == OPCODE_W'(OpJal)) ? ImmJ : ImmB;
        if (op == OPCODE_W'(OpLoad) || op == OPCODE_W'(OpStore)) state_d = StMemAdr;
        else if (op == OPCODE_W'(OpRtype))  state_d = StExecR;
        else if (op == OPCODE_W'(OpItype))  state_d = StExecI;
        else if (op == OPCODE_W'(OpBranch)) state_d = StBranch;
        else if (op == OPCODE_W'(OpJal))    state_d = StJal;
        else if (op == OPCODE_W'(OpJalr))   state_d = StJalr1;
        else if (op == OPCODE_W'(OpLui))    state_d = StLui;
        else begin
          illegal = 1'b1;
          state_d = StFetch;
        end
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        if (op == OPCODE_W'(OpStore)) begin
          ImmSrc  = ImmS;
          state_d = StMemWrite;
        end else begin
          state_d = StMemRead;
        end
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = mem_ok;
        if (mem_ok) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA = SrcARs1;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA = SrcARs1;
        alu_op  = AluOpSub;
        branch  = 1'b1;
        state_d = StFetch;
      end
      StJal: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StJalr1: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        state_d = StJalr2;
      end
      StJalr2: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StLui: begin
        ImmSrc    = ImmU;
        ResultSrc = ResImmExt;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset silences every enable and select so an abandoned instruction writes nothing.
    if (rst) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 3'b000;
      alu_op    = AluOpAdd;
      illegal   = 1'b0;
    end
  end

  assign PCWrite = pc_update | (branch & branch_taken(funct3, zero, neg));

  alu_decoder #(
    .ALU_CTRL_W (ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors against an
// instruction-level model of each RV32I class.
module tb_multicycle_controller;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_JAL = 5, C_JALR = 6,
                 C_LUI = 7, C_ILL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;
  logic [17:0] got;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .neg        (neg),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, illegal};

  // ---------------- reference model ----------------
  function automatic int latency(input int cls);
    case (cls)
      C_LUI, C_BR:           return 3;
      C_R, C_I, C_SW, C_JAL: return 4;
      C_LW, C_JALR:          return 5;
      default:               return 2;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input int cls);
    logic [6:0] r;
    case (cls)
      C_R:     r = 7'b0110011;
      C_I:     r = 7'b0010011;
      C_LW:    r = 7'b0000011;
      C_SW:    r = 7'b0100011;
      C_BR:    r = 7'b1100011;
      C_JAL:   r = 7'b1101111;
      C_JALR:  r = 7'b1100111;
      C_LUI:   r = 7'b0110111;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  // Arithmetic the instruction asks for: add/sub, slt, xor, or, and; others fall back to add.
  function automatic logic [2:0] alu_for(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b100:  return 3'd4;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input int cls, input int cyc, input logic [2:0] f3,
                                           input logic f7, input logic z, input logic n);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm, alu;
    int lat;
    {pcw, adr, mw, irw, rw, ill} = '0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; imm = 3'b000; alu = 3'b000;
    lat = latency(cls);
    if (cyc == 0) begin
      irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10;
    end else if (cyc == 1) begin
      sa = 2'b01; sb = 2'b01; imm = (cls == C_JAL) ? 3'b100 : 3'b010; ill = (cls == C_ILL);
    end else if (cyc == lat - 1 && cls inside {C_R, C_I, C_JAL, C_JALR}) begin
      rw = 1;
    end else begin
      case (cls)
        C_R:  begin sa = 2'b10; sb = 2'b00; alu = alu_for(f3, f7, 1); end
        C_I:  begin sa = 2'b10; sb = 2'b01; alu = alu_for(f3, f7, 0); end
        C_LW: begin
          if (cyc == 2) begin sa = 2'b10; sb = 2'b01; end
          else if (cyc == 3) adr = 1;
          else begin rs = 2'b01; rw = 1; end
        end
        C_SW: begin
          if (cyc == 2) begin sa = 2'b10; sb = 2'b01; imm = 3'b001; end
          else begin adr = 1; mw = 1; end
        end
        C_BR: begin
          sa = 2'b10; alu = 3'b001;
          pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) ||
                (f3 == 3'b100 && n) || (f3 == 3'b101 && !n);
        end
        C_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        C_JALR: begin
          if (cyc == 2) begin sa = 2'b10; sb = 2'b01; end
          else begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        end
        C_LUI: begin imm = 3'b011; rs = 2'b11; rw = 1; end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
  endfunction

  // ---------------- stimulus ----------------
  // Called at a negedge with the DUT in FETCH; returns at the negedge after the last cycle run.
  task automatic run_instr(input string name, input int cls, input logic [6:0] opc,
                           input logic [2:0] f3, input logic f7, input logic z, input logic n,
                           input int max_cyc);
    logic [17:0] e;
    int lat;
    lat = latency(cls);
    if (max_cyc < lat) lat = max_cyc;
    op = opc; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    for (int c = 0; c < lat; c++) begin
`ifdef MEM_READY_EN
      mem_ready = 1'b1;
`else
      mem_ready = 1'($urandom);
`endif
      #1;
      e = exp_ctrl(cls, c, f3, f7, z, n);
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b want %b", name, c, got, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1;
    op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b1; neg = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (got !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero", got);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_instr("add", C_R, opcode_of(C_R), 3'b000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("sub", C_R, opcode_of(C_R), 3'b000, 1'b1, 1'b1, 1'b0, 99);
    run_instr("addi_b30", C_I, opcode_of(C_I), 3'b000, 1'b1, 1'b0, 1'b0, 99);
  endtask

  task automatic test_lw();
    run_instr("lw", C_LW, opcode_of(C_LW), 3'b010, 1'b0, 1'b0, 1'b0, 99);
    run_instr("sw", C_SW, opcode_of(C_SW), 3'b010, 1'b0, 1'b0, 1'b0, 99);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", C_BR, opcode_of(C_BR), 3'b000, 1'b0, 1'b1, 1'b0, 99);
    run_instr("beq_not_taken", C_BR, opcode_of(C_BR), 3'b000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("bge_neg", C_BR, opcode_of(C_BR), 3'b101, 1'b0, 1'b0, 1'b1, 99);
    run_instr("br_f3_010", C_BR, opcode_of(C_BR), 3'b010, 1'b0, 1'b1, 1'b1, 99);
  endtask

  task automatic test_lui_jalr();
    run_instr("lui", C_LUI, opcode_of(C_LUI), 3'b000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("jalr", C_JALR, opcode_of(C_JALR), 3'b000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("jal", C_JAL, opcode_of(C_JAL), 3'b000, 1'b0, 1'b0, 1'b0, 99);
  endtask

  task automatic test_illegal();
    run_instr("illegal_7f", C_ILL, 7'h7F, 3'b000, 1'b0, 1'b0, 1'b0, 99);
    run_instr("after_illegal", C_LUI, opcode_of(C_LUI), 3'b000, 1'b0, 1'b0, 1'b0, 99);
  endtask

  task automatic test_reset_mid();
    // Stop with the DUT sitting in MEMWRITE, then reset it there.
    run_instr("sw_partial", C_SW, opcode_of(C_SW), 3'b010, 1'b0, 1'b0, 1'b0, 3);
    rst = 1'b1;
    #1;
    vectors++;
    if (MemWrite !== 1'b0 || got !== 18'd0) begin
      miscompares++;
      $display("FAIL rst_in_memwrite: got %b want all zero", got);
    end
    @(negedge clk);
    rst = 1'b0;
    run_instr("fetch_after_rst", C_LUI, opcode_of(C_LUI), 3'b000, 1'b0, 1'b0, 1'b0, 99);
  endtask

  task automatic test_random(input int n_instr);
    int cls;
    logic [6:0] opc;
    for (int i = 0; i < n_instr; i++) begin
      cls = int'($urandom_range(0, 8));
      opc = opcode_of(cls);
      if (cls == C_ILL) begin
        opc = 7'($urandom);
        for (int k = 0; k < 8; k++) if (opc == opcode_of(k)) opc = 7'h7F;
      end
      run_instr("random", cls, opc, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 99);
    end
  endtask

`ifdef MEM_READY_EN
  task automatic test_mem_ready();
    logic [17:0] stall_vec, fetch_vec;
    fetch_vec = exp_ctrl(C_LUI, 0, 3'b000, 1'b0, 1'b0, 1'b0);
    stall_vec = fetch_vec & ~18'b10010_00_00_00_000_000_0;
    op = opcode_of(C_LUI); funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (got !== stall_vec) begin
        miscompares++;
        $display("FAIL fetch_stall cycle %0d: got %b want %b", c, got, stall_vec);
      end
      @(negedge clk);
    end
    run_instr("lui_after_stall", C_LUI, opcode_of(C_LUI), 3'b000, 1'b0, 1'b0, 1'b0, 99);
  endtask
`else
  task automatic test_mem_ready();
    // Handshake disabled: a load keeps its fixed length whatever mem_ready does.
    run_instr("lw_ready_ignored", C_LW, opcode_of(C_LW), 3'b010, 1'b0, 1'b0, 1'b0, 99);
    run_instr("sw_ready_ignored", C_SW, opcode_of(C_SW), 3'b010, 1'b0, 1'b0, 1'b0, 99);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_lui_jalr();
    test_illegal();
    test_reset_mid();
    test_mem_ready();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
